// File: rtl/mii_rx_frame_ctrl.sv
// MII receive frame sequencer: preamble/SFD qualification, payload writes into a
// single-frame RX buffer, and a held frame descriptor. Optional stats: RX_FRAME_STATS_EN.
module mii_rx_frame_ctrl #(
   parameter int ADDR_W  = 11,
   parameter int MAX_LEN = 1518,
   parameter int MIN_LEN = 64,
   parameter int MIN_PRE = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              rx_dv,
   output logic              asm_ena,
   input  logic [7:0]        asm_byte,
   input  logic              asm_ren,
   input  logic              asm_err,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              frm_valid,
   output logic [ADDR_W:0]   frm_len,
   output logic [3:0]        frm_status,
   input  logic              frm_ack,
   output logic              overrun,
   output logic [2:0]        dbg_state
`ifdef RX_FRAME_STATS_EN
   ,
   output logic [15:0]       stat_good,
   output logic [15:0]       stat_bad,
   output logic [15:0]       stat_ovr
`endif
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_DATA = 3'd2,
      S_DROP = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [ADDR_W:0] MAX_LEN_C = (ADDR_W+1)'(MAX_LEN);
   localparam logic [ADDR_W:0] MIN_LEN_C = (ADDR_W+1)'(MIN_LEN);
   localparam logic [3:0]      MIN_PRE_C = 4'(MIN_PRE);

   state_t            state_q, state_d;
   logic              rx_dv_q;
   logic [ADDR_W:0]   len_q, len_d;
   logic [3:0]        pre_cnt_q, pre_cnt_d;
   logic [3:0]        status_q, status_d;
   logic [1:0]        gap_q, gap_d;
   logic              ovr_drop_q, ovr_drop_d;
   logic              wr_fire, ovr_fire, desc_load;
   logic              dv_rise, frm_valid_nx;
   logic [3:0]        desc_status;

   // Descriptor handshake: frm_valid rises when a frame is published and holds
   // until a cycle with frm_ack=1, after which it drops; ack while invalid is a no-op.
   assign dv_rise      = rx_dv && !rx_dv_q;
   assign frm_valid_nx = frm_valid && !frm_ack;
   assign desc_status  = {status_q[3:1], status_q[0] | ((len_q < MIN_LEN_C) && !status_q[2])};
   assign dbg_state    = state_q;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      pre_cnt_d  = pre_cnt_q;
      status_d   = status_q;
      gap_d      = gap_q;
      ovr_drop_d = ovr_drop_q;
      wr_fire    = 1'b0;
      ovr_fire   = 1'b0;
      desc_load  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dv_rise) begin
               if (frm_valid_nx) begin
                  state_d    = S_DROP;
                  ovr_drop_d = 1'b1;
                  ovr_fire   = 1'b1;
               end else begin
                  state_d    = S_PRE;
                  len_d      = '0;
                  pre_cnt_d  = '0;
                  status_d   = '0;
                  gap_d      = '0;
                  ovr_drop_d = 1'b0;
               end
            end
         end
         S_PRE: begin
            if (!rx_dv) begin
               state_d = S_IDLE;
            end else if (asm_ren) begin
               if (asm_err) begin
                  status_d[2] = 1'b1;
                  state_d     = S_DROP;
               end else if (asm_byte == 8'h55) begin
                  if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
               end else if (asm_byte == 8'hD5 && pre_cnt_q >= MIN_PRE_C) begin
                  state_d = S_DATA;
                  gap_d   = '0;
               end else begin
                  status_d[2] = 1'b1;
                  state_d     = S_DROP;
               end
            end
         end
         S_DATA: begin
            // A long silence before rx_dv drops means the frame ended mid-byte.
            if (!rx_dv) begin
               if (gap_q >= 2'd2) status_d[3] = 1'b1;
               state_d = S_DONE;
            end else if (asm_ren) begin
               gap_d = '0;
               if (len_q < MAX_LEN_C) begin
                  wr_fire = 1'b1;
                  len_d   = len_q + 1'b1;
               end else begin
                  status_d[1] = 1'b1;
                  state_d     = S_DROP;
               end
            end else if (gap_q != 2'd3) begin
               gap_d = gap_q + 2'd1;
            end
         end
         S_DROP: begin
            if (!rx_dv) begin
               state_d = (!ovr_drop_q && status_q != 4'd0) ? S_DONE : S_IDLE;
            end
         end
         S_DONE: begin
            desc_load = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         // Treat rx_dv as already high so a frame in flight at reset is not re-captured.
         rx_dv_q    <= 1'b1;
         len_q      <= '0;
         pre_cnt_q  <= '0;
         status_q   <= '0;
         gap_q      <= '0;
         ovr_drop_q <= 1'b0;
         asm_ena    <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frm_valid  <= 1'b0;
         frm_len    <= '0;
         frm_status <= '0;
         overrun    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_dv_q    <= rx_dv;
         len_q      <= len_d;
         pre_cnt_q  <= pre_cnt_d;
         status_q   <= status_d;
         gap_q      <= gap_d;
         ovr_drop_q <= ovr_drop_d;
         asm_ena    <= rx_dv && (state_q == S_PRE || state_q == S_DATA);
         wr_en      <= wr_fire;
         if (wr_fire) begin
            wr_addr <= len_q[ADDR_W-1:0];
            wr_data <= asm_byte;
         end
         overrun <= ovr_fire;
         if (desc_load) begin
            frm_valid  <= 1'b1;
            frm_len    <= status_q[2] ? '0 : len_q;
            frm_status <= desc_status;
         end else if (frm_ack) begin
            frm_valid <= 1'b0;
         end
      end
   end

`ifdef RX_FRAME_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         stat_good <= '0;
         stat_bad  <= '0;
         stat_ovr  <= '0;
      end else begin
         if (desc_load && desc_status == 4'd0 && stat_good != 16'hFFFF) stat_good <= stat_good + 16'd1;
         if (desc_load && desc_status != 4'd0 && stat_bad != 16'hFFFF)  stat_bad  <= stat_bad + 16'd1;
         if (ovr_fire && stat_ovr != 16'hFFFF) stat_ovr <= stat_ovr + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mii_rx_frame_ctrl.sv
// Directed bench for mii_rx_frame_ctrl: frame sequences with hand-computed
// descriptors and a write scoreboard fed from an expected queue.
module tb_mii_rx_frame_ctrl;

   localparam int ADDR_W  = 11;
   localparam int MAX_LEN = 1518;

   logic              clock;
   logic              reset_n;
   logic              rx_dv;
   logic              asm_ena;
   logic [7:0]        asm_byte;
   logic              asm_ren;
   logic              asm_err;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              frm_valid;
   logic [ADDR_W:0]   frm_len;
   logic [3:0]        frm_status;
   logic              frm_ack;
   logic              overrun;
   logic [2:0]        dbg_state;
`ifdef RX_FRAME_STATS_EN
   logic [15:0]       stat_good, stat_bad, stat_ovr;
`endif

   int tests  = 0;
   int failed = 0;
   int wr_cnt = 0;
   int ovr_cnt = 0;
   int wr_base, ovr_base;
   logic [ADDR_W+7:0] exp_q[$];
   logic [ADDR_W+7:0] exp_w;

   mii_rx_frame_ctrl #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .MIN_LEN(64), .MIN_PRE(2)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .rx_dv      (rx_dv),
      .asm_ena    (asm_ena),
      .asm_byte   (asm_byte),
      .asm_ren    (asm_ren),
      .asm_err    (asm_err),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frm_valid  (frm_valid),
      .frm_len    (frm_len),
      .frm_status (frm_status),
      .frm_ack    (frm_ack),
      .overrun    (overrun),
      .dbg_state  (dbg_state)
`ifdef RX_FRAME_STATS_EN
      ,
      .stat_good  (stat_good),
      .stat_bad   (stat_bad),
      .stat_ovr   (stat_ovr)
`endif
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // write scoreboard and overrun monitor
   always @(negedge clock) begin
      if (wr_en) begin
         wr_cnt++;
         exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
         tests++;
         assert ({wr_addr, wr_data} === exp_w) else begin
            failed++;
            $error("FAIL wr_write: got addr/data %0h expected %0h", {wr_addr, wr_data}, exp_w);
         end
      end
      if (overrun) ovr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      asm_byte = b;
      asm_ren  = 1'b1;
      @(negedge clock);
      asm_ren  = 1'b0;
      @(negedge clock);
   endtask

   task automatic send_frame(input int npre, input logic [7:0] sfd, input int nbytes,
                             input int base, input bit expect_wr, input bit abort_gap);
      logic [7:0] b;
      rx_dv = 1'b1;
      @(negedge clock);
      repeat (npre) send_byte(8'h55);
      send_byte(sfd);
      for (int i = 0; i < nbytes; i++) begin
         b = 8'(base + i);
         if (expect_wr && i < MAX_LEN) exp_q.push_back({ADDR_W'(i), b});
         send_byte(b);
      end
      if (abort_gap) @(negedge clock);
      rx_dv = 1'b0;
      repeat (5) @(negedge clock);
   endtask

   task automatic ack_desc(input string tag);
      frm_ack = 1'b1;
      @(negedge clock);
      frm_ack = 1'b0;
      check(tag, 32'(frm_valid), 32'd0);
   endtask

   initial begin
      reset_n  = 1'b0;
      rx_dv    = 1'b0;
      asm_byte = 8'h00;
      asm_ren  = 1'b0;
      asm_err  = 1'b0;
      frm_ack  = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_asm_ena", 32'(asm_ena), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_frm_valid", 32'(frm_valid), 32'd0);
      check("rst_frm_len", 32'(frm_len), 32'd0);
      check("rst_frm_status", 32'(frm_status), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // good 64-byte frame
      wr_base = wr_cnt;
      send_frame(7, 8'hD5, 64, 0, 1'b1, 1'b0);
      check("good_writes", 32'(wr_cnt - wr_base), 32'd64);
      check("good_exp_left", 32'(exp_q.size()), 32'd0);
      check("good_valid", 32'(frm_valid), 32'd1);
      check("good_len", 32'(frm_len), 32'd64);
      check("good_status", 32'(frm_status), 32'h0);

      // frame while the buffer is held: overrun, no writes, descriptor kept
      wr_base  = wr_cnt;
      ovr_base = ovr_cnt;
      send_frame(7, 8'hD5, 10, 8'h80, 1'b0, 1'b0);
      check("ovr_pulses", 32'(ovr_cnt - ovr_base), 32'd1);
      check("ovr_writes", 32'(wr_cnt - wr_base), 32'd0);
      check("ovr_valid", 32'(frm_valid), 32'd1);
      check("ovr_len_kept", 32'(frm_len), 32'd64);
      check("ovr_status_kept", 32'(frm_status), 32'h0);

      // ack on the same cycle as the next rise: frame accepted, 20-byte runt
      wr_base  = wr_cnt;
      ovr_base = ovr_cnt;
      frm_ack  = 1'b1;
      rx_dv    = 1'b1;
      @(negedge clock);
      frm_ack  = 1'b0;
      send_frame(7, 8'hD5, 20, 8'h40, 1'b1, 1'b0);
      check("runt_no_ovr", 32'(ovr_cnt - ovr_base), 32'd0);
      check("runt_writes", 32'(wr_cnt - wr_base), 32'd20);
      check("runt_valid", 32'(frm_valid), 32'd1);
      check("runt_len", 32'(frm_len), 32'd20);
      check("runt_status", 32'(frm_status), 32'h1);
      ack_desc("runt_ack_clear");

      // short preamble: one 0x55 then SFD
      wr_base = wr_cnt;
      send_frame(1, 8'hD5, 4, 8'h10, 1'b0, 1'b0);
      check("pre_writes", 32'(wr_cnt - wr_base), 32'd0);
      check("pre_valid", 32'(frm_valid), 32'd1);
      check("pre_len", 32'(frm_len), 32'd0);
      check("pre_status", 32'(frm_status), 32'h4);
      ack_desc("pre_ack_clear");

      // rx_dv drops after a nibble-boundary gap: aborted, still described
      wr_base = wr_cnt;
      send_frame(7, 8'hD5, 70, 8'h20, 1'b1, 1'b1);
      check("abort_writes", 32'(wr_cnt - wr_base), 32'd70);
      check("abort_len", 32'(frm_len), 32'd70);
      check("abort_status", 32'(frm_status), 32'h8);
      ack_desc("abort_ack_clear");

      // oversize: 1600 bytes, only MAX_LEN written
      wr_base = wr_cnt;
      send_frame(7, 8'hD5, 1600, 0, 1'b1, 1'b0);
      check("trunc_writes", 32'(wr_cnt - wr_base), 32'd1518);
      check("trunc_exp_left", 32'(exp_q.size()), 32'd0);
      check("trunc_len", 32'(frm_len), 32'd1518);
      check("trunc_status", 32'(frm_status), 32'h2);
      ack_desc("trunc_ack_clear");

      // reset pulse at payload byte 30
      wr_base = wr_cnt;
      rx_dv = 1'b1;
      @(negedge clock);
      repeat (7) send_byte(8'h55);
      send_byte(8'hD5);
      for (int i = 0; i < 30; i++) begin
         exp_q.push_back({ADDR_W'(i), 8'(i + 5)});
         send_byte(8'(i + 5));
      end
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      check("mid_rst_asm_ena", 32'(asm_ena), 32'd0);
      check("mid_rst_wr_en", 32'(wr_en), 32'd0);
      check("mid_rst_valid", 32'(frm_valid), 32'd0);
      check("mid_rst_len", 32'(frm_len), 32'd0);
      check("mid_rst_status", 32'(frm_status), 32'd0);
      check("mid_rst_state", 32'(dbg_state), 32'd0);
      for (int i = 30; i < 40; i++) send_byte(8'(i + 5));
      rx_dv = 1'b0;
      repeat (5) @(negedge clock);
      check("mid_rst_writes", 32'(wr_cnt - wr_base), 32'd30);
      check("mid_rst_no_desc", 32'(frm_valid), 32'd0);

      // next good frame reports its own length
      wr_base = wr_cnt;
      send_frame(7, 8'hD5, 100, 8'hA0, 1'b1, 1'b0);
      check("post_rst_writes", 32'(wr_cnt - wr_base), 32'd100);
      check("post_rst_valid", 32'(frm_valid), 32'd1);
      check("post_rst_len", 32'(frm_len), 32'd100);
      check("post_rst_status", 32'(frm_status), 32'h0);
      check("final_exp_left", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/mii_rx_frame_ctrl.md
Name: mii_rx_frame_ctrl

Overview:
- Sequences the MII receive path: gates the nibble-to-byte assembler enable from rx_dv, qualifies preamble/SFD, and writes payload bytes into a single-frame RX buffer RAM.
- Publishes a frame descriptor (length, status) to the host side, then holds the buffer until it is acknowledged.
- Sits between the nibble-to-byte assembler and the frame RAM / host register interface.

Parameters:
- ADDR_W, 11, RX buffer address width; the buffer holds 2^ADDR_W bytes.
- MAX_LEN, 1518, maximum payload length in bytes, counted after the SFD; must be <= 2^ADDR_W.
- MIN_LEN, 64, minimum good frame length in bytes.
- MIN_PRE, 2, minimum count of 0x55 bytes required before the SFD.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous reset, active-low.
- rx_dv  in  1  MII receive data valid, already synchronised to clock.
- asm_ena  out  1  enable to the nibble-to-byte assembler.
- asm_byte  in  8  assembled byte from the assembler.
- asm_ren  in  1  one-cycle strobe: asm_byte is valid.
- asm_err  in  1  preamble error flag from the assembler.
- wr_en  out  1  RX buffer write strobe.
- wr_addr  out  ADDR_W  RX buffer write address.
- wr_data  out  8  RX buffer write data.
- frm_valid  out  1  descriptor valid; held high until frm_ack.
- frm_len  out  ADDR_W+1  byte count of the frame written to the buffer.
- frm_status  out  4  bit0 runt, bit1 oversize/truncated, bit2 preamble error, bit3 aborted.
- frm_ack  in  1  host has consumed the descriptor and the buffer.
- overrun  out  1  one-cycle pulse: a frame was dropped because the buffer was busy.

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE; all outputs 0; internal counters 0. Reset mid-frame abandons the frame with no descriptor.
- asm_ena is registered: asm_ena <= rx_dv while in PRE or DATA, else 0.
- States:
  - IDLE
    - rx_dv rising and frm_valid=0 -> PRE; clear len and pre_cnt.
    - rx_dv rising and frm_valid=1 -> DROP; pulse overrun for 1 cycle.
  - PRE, on asm_ren:
    - byte 0x55 -> pre_cnt++ (saturating at 15).
    - byte 0xD5 with pre_cnt >= MIN_PRE -> DATA.
    - 0xD5 with pre_cnt < MIN_PRE, any other byte, or asm_err=1 -> DROP with status bit2.
    - rx_dv falls in PRE -> IDLE; no descriptor.
  - DATA
    - Each asm_ren: wr_en=1 on the next cycle, wr_data = byte, wr_addr = len; then len++.
    - When len reaches MAX_LEN: further bytes are not written; status bit1 set; -> DROP.
    - rx_dv falls -> DONE.
  - DROP
    - Ignores bytes, no writes. When rx_dv=0 -> DONE if any status bit was set in PRE/DATA, else IDLE.
    - An overrun drop always returns to IDLE and leaves the existing descriptor untouched.
  - DONE
    - One cycle: frm_len <= len; status bit0 = (len < MIN_LEN).
    - A descriptor with bit2 set carries frm_len=0.
    - frm_valid <= 1; -> IDLE.
- frm_valid clears on the cycle after frm_ack=1. frm_ack while frm_valid=0 is ignored.
- If frm_ack and a new rx_dv rise occur on the same cycle, the frame is accepted: the free check uses the next-state value of frm_valid.
- Status bit3 is set if rx_dv drops at a nibble boundary. This is detected by asm_ren not having fired within 2 cycles after the last byte position, and still yields a descriptor.
- wr_en latency: exactly 1 cycle after asm_ren. Address wrap-around is impossible, because len is capped at MAX_LEN.

Optional Feature:
- Macro RX_FRAME_STATS_EN.
- Defined: adds outputs stat_good[15:0], stat_bad[15:0], stat_ovr[15:0].
  - Saturating counters, incremented in DONE (good when status==0, else bad) and on each overrun pulse.
  - Cleared only by reset.
- Undefined: ports and logic absent; core behaviour unchanged.

Test Plan:
- 7x0x55, 0xD5, then 64 payload bytes 0x00..0x3F, rx_dv low -> 64 writes at addr 0..63 with matching data; frm_valid=1, frm_len=64, frm_status=0.
- Same preamble and SFD, 20 payload bytes -> frm_len=20, frm_status=0x1 (runt).
- 1x0x55 then 0xD5 (MIN_PRE=2) -> no writes, frm_status=0x4, frm_len=0.
- 1600-byte payload -> exactly 1518 writes, frm_len=1518, frm_status=0x2.
- Second frame starts while frm_valid=1 -> overrun pulses once, zero writes; the first descriptor is unchanged. Assert frm_ack, then send a third frame -> accepted normally.
- reset_n=0 for 1 cycle at payload byte 30 -> all outputs 0, no descriptor. The next good frame reports frm_len equal to its own length.
